npu_sram_vector_reader: RTL and testbench

- Avalon-MM read master for one port of the 16K x 16 dual-port on-chip NPU SRAM.
- On a command it fetches a strided vector of 16-bit words and presents them as a valid/ready stream with a last marker.
- Feeds the NPU MAC array from weight/activation buffers.
- The SRAM has a fixed read latency of 1 cycle and no waitrequest, so backpressure is absorbed by a credit-limited 2-entry output buffer.

---
 rtl/npu_sram_pkg.sv | 20 ++
 rtl/npu_sram_vector_reader_if.sv | 39 +++
 rtl/npu_fifo2.sv | 60 ++++++
 rtl/npu_sram_vector_reader.sv | 131 +++++++++++++
 tb/tb_npu_sram_vector_reader.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/npu_sram_pkg.sv
// Shared constants and types for blocks that read the 16K x 16 dual-port NPU SRAM.
package npu_sram_pkg;

  localparam int SRAM_ADDR_W     = 14;
  localparam int SRAM_DATA_W     = 16;
  localparam int SRAM_DEPTH      = 16384;
  localparam int SRAM_RD_LATENCY = 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } reader_state_e;

  typedef struct packed {
    logic [SRAM_DATA_W-1:0] data;
    logic                   last;
  } stream_beat_t;

endpackage

// File: rtl/npu_sram_vector_reader_if.sv
// Command, Avalon-MM read and output stream signals of the NPU SRAM vector reader.
interface npu_sram_vector_reader_if #(
  parameter int ADDR_W = npu_sram_pkg::SRAM_ADDR_W,
  parameter int DATA_W = npu_sram_pkg::SRAM_DATA_W,
  parameter int LEN_W  = 15
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic [ADDR_W-1:0]   cmd_base;
  logic [ADDR_W-1:0]   cmd_stride;
  logic [LEN_W-1:0]    cmd_len;

  logic [ADDR_W-1:0]   m_address;
  logic                m_chipselect;
  logic                m_write;
  logic [DATA_W/8-1:0] m_byteenable;
  logic                m_clken;
  logic [DATA_W-1:0]   m_readdata;

  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_data;
  logic                out_last;

  // The reader is the Avalon master and the stream source.
  modport master (
    input  cmd_valid, cmd_base, cmd_stride, cmd_len, m_readdata, out_ready,
    output cmd_ready, m_address, m_chipselect, m_write, m_byteenable, m_clken,
           out_valid, out_data, out_last
  );

  modport slave (
    output cmd_valid, cmd_base, cmd_stride, cmd_len, m_readdata, out_ready,
    input  cmd_ready, m_address, m_chipselect, m_write, m_byteenable, m_clken,
           out_valid, out_data, out_last
  );

endinterface

// File: rtl/npu_fifo2.sv
// Two-entry synchronous FIFO of {data, last} stream beats for NPU stream blocks.
module npu_fifo2
  import npu_sram_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  stream_beat_t din,
  output stream_beat_t dout,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  stream_beat_t mem_q [2];
  stream_beat_t mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only taken when a pop frees a slot in the same cycle.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/npu_sram_vector_reader.sv
// Avalon-MM read master that streams a strided vector of words out of one NPU SRAM port.
module npu_sram_vector_reader
  import npu_sram_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W,
  parameter int LEN_W  = 15
) (
  input  logic                     clk,
  input  logic                     reset_n,
  npu_sram_vector_reader_if.master bus,
  output logic                     busy,
  output logic                     done
);

  reader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;
  logic              done_q, done_d;

  stream_beat_t      fifo_din, fifo_dout, head;
  logic [1:0]        fifo_count;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic              pop, credit_ok, issue;

  assign bus.m_write      = 1'b0;
  assign bus.m_byteenable = {(DATA_W/8){1'b1}};
  assign bus.m_clken      = 1'b1;
  assign bus.cmd_ready    = (state_q == IDLE);
  assign busy             = (state_q == ISSUE) || (state_q == DRAIN);
  assign done             = done_q;

  // The stream head is the buffer when it holds anything, otherwise the word arriving from SRAM.
  always_comb begin
    fifo_din.data = bus.m_readdata;
    fifo_din.last = inflight_last_q;
    head          = fifo_empty ? fifo_din : fifo_dout;
    bus.out_valid = !fifo_empty || inflight_q;
    bus.out_data  = head.data;
    bus.out_last  = head.last && bus.out_valid;
  end

  // A word consumed straight off the SRAM bus never needs a buffer slot.
  always_comb begin
    pop              = bus.out_valid && bus.out_ready;
    fifo_pop         = pop && !fifo_empty;
    fifo_push        = inflight_q && !(fifo_empty && pop) && (!fifo_full || fifo_pop);
    credit_ok        = ({1'b0, fifo_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    issue            = (state_q == ISSUE) && credit_ok;
    bus.m_chipselect = issue;
    bus.m_address    = cur_addr_q;
  end

  npu_fifo2 u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d         = state_q;
    cur_addr_d      = cur_addr_q;
    stride_d        = stride_q;
    remaining_d     = remaining_q;
    inflight_d      = issue;
    inflight_last_d = issue && (remaining_q == LEN_W'(1));
    done_d          = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          cur_addr_d  = bus.cmd_base;
          stride_d    = bus.cmd_stride;
          remaining_d = bus.cmd_len;
          if (bus.cmd_len != '0) begin
            state_d = ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (issue) begin
          cur_addr_d  = cur_addr_q + stride_q;
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Stay here through the done cycle so cmd_ready only rises afterwards.
        if (done_q) begin
          state_d = IDLE;
        end else if (pop && bus.out_last) begin
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      cur_addr_q      <= '0;
      stride_q        <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cur_addr_q      <= cur_addr_d;
      stride_q        <= stride_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
    end
  end

endmodule

// File: tb/tb_npu_sram_vector_reader.sv
// Directed bench for the NPU SRAM vector reader with an SRAM model and a beat/address scoreboard.
module tb_npu_sram_vector_reader;

  logic clk;
  logic reset_n;
  logic busy;
  logic done;

  npu_sram_vector_reader_if bus ();

  npu_sram_vector_reader dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy),
    .done    (done)
  );

  logic [15:0] mem [16384];
  int          compared   = 0;
  int          mismatched = 0;
  logic [13:0] exp_addr_q [$];
  logic [16:0] exp_beat_q [$];
  int          outstanding = 0;
  int          pops_total  = 0;
  logic        stall_q     = 1'b0;
  logic [15:0] stall_data  = '0;
  logic        mon_pop;
  logic [13:0] mon_addr;
  logic [16:0] mon_beat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM port model: one-cycle read latency, no waitrequest.
  always @(posedge clk) begin
    if (bus.m_chipselect) bus.m_readdata <= mem[bus.m_address];
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Bus monitor: address/beat scoreboard, credit model and stall stability.
  always @(negedge clk) begin
    if (!reset_n) begin
      outstanding = 0;
      stall_q     = 1'b0;
    end else begin
      mon_pop = bus.out_valid && bus.out_ready;
      if (bus.m_chipselect) begin
        check_output("credit_available", 32'((outstanding - int'(mon_pop)) < 2), 32'd1);
        check_output("read_expected", 32'(exp_addr_q.size() != 0), 32'd1);
        if (exp_addr_q.size() != 0) begin
          mon_addr = exp_addr_q.pop_front();
          check_output("read_addr", 32'(bus.m_address), 32'(mon_addr));
        end
      end
      if (stall_q) begin
        check_output("stall_valid", 32'(bus.out_valid), 32'd1);
        check_output("stall_data", 32'(bus.out_data), 32'(stall_data));
      end
      if (mon_pop) begin
        pops_total++;
        check_output("beat_expected", 32'(exp_beat_q.size() != 0), 32'd1);
        if (exp_beat_q.size() != 0) begin
          mon_beat = exp_beat_q.pop_front();
          check_output("beat_data_last", 32'({bus.out_data, bus.out_last}), 32'(mon_beat));
        end
      end
      outstanding = outstanding + int'(bus.m_chipselect) - int'(mon_pop);
      stall_q     = bus.out_valid && !bus.out_ready;
      stall_data  = bus.out_data;
    end
  end

  task automatic push_expect(input logic [13:0] base, input logic [13:0] stride, input logic [14:0] len);
    logic [13:0] a;
    a = base;
    for (int i = 0; i < int'(len); i++) begin
      exp_addr_q.push_back(a);
      exp_beat_q.push_back({mem[a], (i == int'(len) - 1)});
      a = a + stride;
    end
  endtask

  task automatic apply_stimulus(input logic [13:0] base, input logic [13:0] stride,
                                input logic [14:0] len, input bit hold);
    bit ready_seen;
    ready_seen = 1'b0;
    for (int n = 0; n < 100 && !ready_seen; n++) begin
      @(negedge clk);
      ready_seen = bus.cmd_ready;
    end
    check_output("cmd_ready_wait", 32'(ready_seen), 32'd1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_base   = base;
    bus.cmd_stride = stride;
    bus.cmd_len    = len;
    push_expect(base, stride, len);
    @(posedge clk);
    #1;
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, input bit toggle);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        if (toggle) bus.out_ready = ((n % 4) == 0) || ((n % 4) == 3);
      end
    end
    check_output({tag, "_done_seen"}, 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    check_output({tag, "_cs"}, 32'(bus.m_chipselect), 32'd0);
    check_output({tag, "_addr"}, 32'(bus.m_address), 32'd0);
    check_output({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check_output({tag, "_out_last"}, 32'(bus.out_last), 32'd0);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    bit reached;
    bit dn;
    bit acc;
    int start;
    for (int a = 0; a < 16384; a++) mem[a] = 16'(a);
    reset_n        = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_base   = '0;
    bus.cmd_stride = '0;
    bus.cmd_len    = '0;
    bus.out_ready  = 1'b1;
    #12;
    check_reset_state("rst");
    check_output("rst_m_write", 32'(bus.m_write), 32'd0);
    check_output("rst_byteenable", 32'(bus.m_byteenable), 32'h3);
    check_output("rst_clken", 32'(bus.m_clken), 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    $display("[TB] step 1: base 0x0010 stride 1 len 4, cycle-exact timing");
    apply_stimulus(14'h0010, 14'h0001, 15'd4, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check_output($sformatf("t1_cs_c%0d", k), 32'(bus.m_chipselect), 32'(k <= 4));
      if (k <= 4) check_output($sformatf("t1_addr_c%0d", k), 32'(bus.m_address), 32'(16 + k - 1));
      check_output($sformatf("t1_valid_c%0d", k), 32'(bus.out_valid), 32'(k >= 2 && k <= 5));
      check_output($sformatf("t1_last_c%0d", k), 32'(bus.out_last), 32'(k == 5));
      check_output($sformatf("t1_done_c%0d", k), 32'(done), 32'(k == 6));
      check_output($sformatf("t1_cmd_ready_c%0d", k), 32'(bus.cmd_ready), 32'(k == 7));
    end

    $display("[TB] step 2: address wrap base 0x3FFE stride 3 len 3");
    apply_stimulus(14'h3FFE, 14'h0003, 15'd3, 1'b0);
    wait_done("t2", 100, 1'b0);

    $display("[TB] step 3: len 8 with out_ready toggling");
    apply_stimulus(14'h0800, 14'h0007, 15'd8, 1'b0);
    wait_done("t3", 200, 1'b1);

    $display("[TB] step 4: len 0");
    apply_stimulus(14'h0123, 14'h0001, 15'd0, 1'b0);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      check_output($sformatf("t4_done_c%0d", k), 32'(done), 32'(k == 1));
      check_output($sformatf("t4_cs_c%0d", k), 32'(bus.m_chipselect), 32'd0);
      check_output($sformatf("t4_valid_c%0d", k), 32'(bus.out_valid), 32'd0);
    end

    $display("[TB] step 5: reset mid-vector, then len 2");
    apply_stimulus(14'h0200, 14'h0001, 15'd10, 1'b0);
    start   = pops_total;
    reached = 1'b0;
    for (int n = 0; n < 100 && !reached; n++) begin
      @(negedge clk);
      #1;
      reached = (pops_total - start) >= 3;
    end
    check_output("t5_three_popped", 32'(reached), 32'd1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_state("t5_rst");
    exp_addr_q.delete();
    exp_beat_q.delete();
    @(negedge clk);
    check_output("t5_done_in_reset", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    apply_stimulus(14'h0300, 14'h0002, 15'd2, 1'b0);
    wait_done("t5", 100, 1'b0);

    $display("[TB] step 6: cmd_valid held high across two commands");
    apply_stimulus(14'h0100, 14'h0002, 15'd3, 1'b1);
    bus.cmd_base   = 14'h0200;
    bus.cmd_stride = 14'h0005;
    bus.cmd_len    = 15'd2;
    push_expect(14'h0200, 14'h0005, 15'd2);
    dn  = 1'b0;
    acc = 1'b0;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      if (busy) check_output("t6_ready_low_when_busy", 32'(bus.cmd_ready), 32'd0);
      if (done) dn = 1'b1;
      if (bus.cmd_ready) acc = 1'b1;
    end
    check_output("t6_second_after_done", 32'(dn), 32'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    wait_done("t6", 100, 1'b0);

    repeat (3) @(negedge clk);
    check_output("exp_addr_drained", 32'(exp_addr_q.size()), 32'd0);
    check_output("exp_beat_drained", 32'(exp_beat_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
